id_stage_ctrl: RTL and testbench
================================

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, listed first among the ports.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port if_valid: input, 1 bit, fetch presents an instruction.
REQ-005 Port if_inst: input, 32 bits, fetched instruction.
REQ-006 Port if_pc: input, 32 bits, PC of if_inst.
REQ-007 Port id_ready: output, 1 bit, ID accepts if_inst this cycle.
REQ-008 Port imm_type: output, 3 bits, immediate format select driven to the immediate generator from the held ID instruction.
REQ-009 Port imm_in: input, 32 bits, immediate generator result for the held ID instruction.
REQ-010 Port flush: input, 1 bit, kill ID and EX contents (redirect).
REQ-011 Port ex_ready: input, 1 bit, EX consumes the ex_* bundle.
REQ-012 Port ex_valid: output, 1 bit, ex_* bundle valid.
REQ-013 Port ex_inst: output, 32 bits, registered instruction.
REQ-014 Port ex_pc: output, 32 bits, registered PC.
REQ-015 Port ex_imm: output, 32 bits, registered immediate.
REQ-016 Port ex_rd: output, 5 bits, registered inst[11:7].
REQ-017 Port ex_is_load: output, 1 bit, registered opcode==0000011.

Function
REQ-018 imm_type decode from ID opcode SHALL be: 0010011/0000011/1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 0110111/0010111 -> 011; 1101111 -> 100; any other opcode or ID empty -> 111.
REQ-019 ID register states SHALL be EMPTY and FULL; the load-use hold is the FULL state with hazard asserted.
REQ-020 ex_free = !ex_valid || ex_ready; advance = FULL && ex_free && !hazard && !flush.
REQ-021 id_ready = !flush && (EMPTY || advance), combinational.
REQ-022 When if_valid && id_ready, if_inst/if_pc SHALL be captured into ID (state FULL); when advance and no capture, state SHALL become EMPTY.
REQ-023 On advance, the EX register SHALL load ID inst, pc, imm_in, rd, is_load and set ex_valid=1.
REQ-024 When ex_ready && !advance (bubble), ex_valid SHALL clear to 0; when ex_valid && !ex_ready, all ex_* outputs SHALL hold.
REQ-025 Latency: an instruction accepted in cycle N SHALL appear on ex_* no earlier than cycle N+1; with no stalls, throughput is one per cycle.
REQ-026 flush SHALL have highest priority: next cycle ID is EMPTY and ex_valid=0, regardless of if_valid, ex_ready, or hazard.
REQ-027 Non-valid ex_* data fields SHALL retain their last values (only ex_valid is qualified).

Reset
REQ-028 While rst_n=0: ID EMPTY, ex_valid=0, ex_inst/ex_pc/ex_imm=0, ex_rd=0, ex_is_load=0; therefore imm_type=111 and id_ready=1 (absent flush).
REQ-029 Reset asserted mid-transfer SHALL discard ID and EX contents without a partial EX update.

Configuration
REQ-030 Macro LOAD_USE_HAZARD_EN defined: hazard = FULL && ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==ID rs1 for imm_type != 011/100, or ex_rd==ID rs2 for imm_type 001/010 or opcode 0110011); exactly one bubble SHALL be inserted, then ID advances.
REQ-031 Macro LOAD_USE_HAZARD_EN undefined: hazard SHALL be constant 0, and no comparator logic is built.

Verification
REQ-032 Reset, then if_valid=1 with if_inst=0x00500093 (addi x1,x0,5) and ex_ready=1 -> imm_type=000; next cycle ex_valid=1, ex_imm=0x00000005, ex_rd=1.
REQ-033 Back-to-back sw/beq/lui/jal with ex_ready=1 -> imm_type sequence 001,010,011,100; one ex_valid per cycle, order preserved.
REQ-034 ex_ready=0 for 3 cycles with ID FULL and EX valid -> id_ready=0, ex_* stable; ex_ready=1 -> flow resumes without loss or duplication.
REQ-035 flush=1 with ID FULL, EX valid, and if_valid=1 -> next cycle ex_valid=0, ID EMPTY, the flush-cycle instruction is not captured.
REQ-036 With LOAD_USE_HAZARD_EN: lw x5,0(x1) followed by add x6,x5,x2 -> one cycle of ex_valid=0 between them; without the macro -> no bubble.
REQ-037 Assert rst_n=0 during an ex_ready=0 stall -> all outputs take their REQ-028 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode-stage holding register and ID->EX pipeline register.
// The ID register holds one fetched instruction. Its state is EMPTY or FULL.
// It hands the instruction on to the EX register through a valid/ready handshake.
// While ID is full, it drives imm_type to the external immediate generator.
// The generator's result (imm_in) is captured into EX together with the instruction.
// Optional feature: define LOAD_USE_HAZARD_EN to build the load-use hazard detector.
// That detector holds a dependent instruction in ID for exactly one bubble.
// When the macro is left undefined, hazard is tied to 0 and no comparators exist.
module id_stage_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [2:0]  imm_type,
  input  logic [31:0] imm_in,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_is_load
);

  // RV32 major opcodes that select an immediate format
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // immediate format codes presented to the immediate generator
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef enum logic {
    ID_EMPTY = 1'b0,
    ID_FULL  = 1'b1
  } id_state_e;

  id_state_e   state_q, state_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_inst_q, ex_inst_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_is_load_q, ex_is_load_d;

  logic [6:0]  id_opcode;
  logic        id_full;
  logic        hazard;
  logic        ex_free;
  logic        advance;
  logic        capture;

  assign id_opcode = id_inst_q[6:0];
  assign id_full   = (state_q == ID_FULL);

  // Immediate format decode of the held ID instruction; an empty ID reports "none"
  always_comb begin
    imm_type = IMM_NONE;
    if (id_full) begin
      case (id_opcode)
        OP_IMM, OP_LOAD, OP_JALR: imm_type = IMM_I;
        OP_STORE:                 imm_type = IMM_S;
        OP_BRANCH:                imm_type = IMM_B;
        OP_LUI, OP_AUIPC:         imm_type = IMM_U;
        OP_JAL:                   imm_type = IMM_J;
        default:                  imm_type = IMM_NONE;
      endcase
    end
  end

`ifdef LOAD_USE_HAZARD_EN
  logic uses_rs1;
  logic uses_rs2;
  logic rs1_match;
  logic rs2_match;

  // Load-use detection: the instruction in ID reads the register that the valid load in EX writes.
  // Once the bubble is inserted, ex_valid drops and the hazard clears by itself, so exactly one bubble results.
  always_comb begin
    uses_rs1  = (imm_type != IMM_U) && (imm_type != IMM_J);
    uses_rs2  = (imm_type == IMM_S) || (imm_type == IMM_B) || (id_opcode == OP_REG);
    rs1_match = uses_rs1 && (id_inst_q[19:15] == ex_rd_q);
    rs2_match = uses_rs2 && (id_inst_q[24:20] == ex_rd_q);
    hazard    = id_full && ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                (rs1_match || rs2_match);
  end
`else
  assign hazard = 1'b0;
`endif

  // Handshake terms: EX can take a new bundle when empty or draining, and flush overrides everything
  always_comb begin
    ex_free  = !ex_valid_q || ex_ready;
    advance  = id_full && ex_free && !hazard && !flush;
    id_ready = !flush && (!id_full || advance);
    capture  = if_valid && id_ready;
  end

  // ID next state: flush empties the register; a capture refills it (even while it is advancing); an advance alone drains it
  always_comb begin
    state_d   = state_q;
    id_inst_d = id_inst_q;
    id_pc_d   = id_pc_q;
    if (flush) begin
      state_d = ID_EMPTY;
    end else if (capture) begin
      state_d   = ID_FULL;
      id_inst_d = if_inst;
      id_pc_d   = if_pc;
    end else if (advance) begin
      state_d = ID_EMPTY;
    end
  end

  // EX next state: only ex_valid is qualified; the data fields change only on advance
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_inst_d    = ex_inst_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (advance) begin
      ex_valid_d   = 1'b1;
      ex_inst_d    = id_inst_q;
      ex_pc_d      = id_pc_q;
      ex_imm_d     = imm_in;
      ex_rd_d      = id_inst_q[11:7];
      ex_is_load_d = (id_opcode == OP_LOAD);
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ID_EMPTY;
      id_inst_q <= 32'd0;
      id_pc_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      id_inst_q <= id_inst_d;
      id_pc_q   <= id_pc_d;
    end
  end

  // EX pipeline register; the asynchronous clear keeps a reset from leaving a half-written bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_inst_q    <= 32'd0;
      ex_pc_q      <= 32'd0;
      ex_imm_q     <= 32'd0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_inst_q    <= ex_inst_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_inst    = ex_inst_q;
  assign ex_pc      = ex_pc_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: self-checking bench for id_stage_ctrl using a slot-level reference model.
// The LOAD_USE_HAZARD_EN macro selects the hazard expectations to match the RTL build.
module tb_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic        id_ready;
  logic [2:0]  imm_type;
  logic [31:0] imm_in = 32'd0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_is_load;

  int total = 0;
  int bad = 0;

  id_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .imm_type(imm_type), .imm_in(imm_in), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  // reference model: one optional instruction slot in ID, one bundle slot in EX
  bit          m_id_v = 0;
  logic [31:0] m_id_inst = 32'd0, m_id_pc = 32'd0;
  bit          m_ex_v = 0;
  logic [31:0] m_ex_inst = 32'd0, m_ex_pc = 32'd0, m_ex_imm = 32'd0;
  logic [4:0]  m_ex_rd = 5'd0;
  bit          m_ex_ld = 0;

  function automatic logic [2:0] ref_type(input bit v, input logic [31:0] i);
    if (!v) return 3'd7;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 3'd0;
      7'h23:               return 3'd1;
      7'h63:               return 3'd2;
      7'h37, 7'h17:        return 3'd3;
      7'h6F:               return 3'd4;
      default:             return 3'd7;
    endcase
  endfunction

  // standard RV32 immediate generator, standing in for the external block
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'd0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_hazard();
`ifdef LOAD_USE_HAZARD_EN
    logic [2:0] t;
    bit r1, r2;
    if (!(m_id_v && m_ex_v && m_ex_ld && m_ex_rd != 5'd0)) return 1'b0;
    t  = ref_type(m_id_v, m_id_inst);
    r1 = (t != 3'd3) && (t != 3'd4) && (m_id_inst[19:15] == m_ex_rd);
    r2 = ((t == 3'd1) || (t == 3'd2) || (m_id_inst[6:0] == 7'h33)) && (m_id_inst[24:20] == m_ex_rd);
    return r1 || r2;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ref_adv();
    return m_id_v && (!m_ex_v || ex_ready) && !ref_hazard() && !flush;
  endfunction

  function automatic bit ref_idr();
    return !flush && (!m_id_v || ref_adv());
  endfunction

  // apply inputs at the falling edge, then settle before any check
  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit fl, input bit er);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    flush    = fl;
    ex_ready = er;
    imm_in   = ref_imm(m_id_inst, ref_type(m_id_v, m_id_inst));
    #1;
  endtask

  // advance the model across one rising edge, returning at the next falling edge
  task automatic tick();
    bit adv, cap, fl, er;
    logic [31:0] imm, ci, cp;
    adv = ref_adv();
    cap = if_valid && ref_idr();
    fl  = flush;
    er  = ex_ready;
    ci  = if_inst;
    cp  = if_pc;
    imm = ref_imm(m_id_inst, ref_type(m_id_v, m_id_inst));
    @(posedge clk);
    if (!rst_n) begin
      m_id_v = 0; m_ex_v = 0; m_id_inst = 0; m_id_pc = 0;
      m_ex_inst = 0; m_ex_pc = 0; m_ex_imm = 0; m_ex_rd = 0; m_ex_ld = 0;
    end else if (fl) begin
      m_id_v = 0;
      m_ex_v = 0;
    end else begin
      if (adv) begin
        m_ex_v = 1; m_ex_inst = m_id_inst; m_ex_pc = m_id_pc; m_ex_imm = imm;
        m_ex_rd = m_id_inst[11:7]; m_ex_ld = (m_id_inst[6:0] == 7'h03);
      end else if (er) begin
        m_ex_v = 0;
      end
      if (cap) begin
        m_id_v = 1; m_id_inst = ci; m_id_pc = cp;
      end else if (adv) begin
        m_id_v = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 32'd0, 32'd0, 0, 1);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1, 32'h00500093, 32'h40, 0, 1);
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
    total++;
    if (imm_type !== 3'd7) begin bad++; $display("FAIL reset_imm_type got=%0d exp=7", imm_type); end
    total++;
    if ({ex_inst, ex_pc, ex_imm, ex_rd, ex_is_load} !== 102'd0) begin
      bad++; $display("FAIL reset_ex_data got inst=%h pc=%h imm=%h rd=%0d ld=%b exp all zero",
                      ex_inst, ex_pc, ex_imm, ex_rd, ex_is_load);
    end
    tick();
    $display("reset: outputs checked while rst_n=0");
  endtask

  task automatic test_addi();
    drive(1, 32'h00500093, 32'h100, 0, 1);
    total++;
    if (imm_type !== 3'd7) begin bad++; $display("FAIL addi_type_empty got=%0d exp=7", imm_type); end
    tick();
    drive(0, 32'd0, 32'd0, 0, 1);
    total++;
    if (imm_type !== 3'd0) begin bad++; $display("FAIL addi_imm_type got=%0d exp=0", imm_type); end
    tick();
    drive(0, 32'd0, 32'd0, 0, 1);
    total++;
    if (ex_valid !== 1'b1 || ex_imm !== 32'd5 || ex_rd !== 5'd1 || ex_inst !== 32'h00500093 || ex_pc !== 32'h100) begin
      bad++; $display("FAIL addi_ex got v=%b imm=%h rd=%0d inst=%h pc=%h exp v=1 imm=5 rd=1 inst=00500093 pc=100",
                      ex_valid, ex_imm, ex_rd, ex_inst, ex_pc);
    end
    tick();
    $display("addi: ex_imm=%h ex_rd=%0d", ex_imm, ex_rd);
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4];
    logic [2:0]  typ [4];
    seq[0] = 32'h0020A423; typ[0] = 3'd1;   // sw x2,8(x1)
    seq[1] = 32'h00208863; typ[1] = 3'd2;   // beq x1,x2,16
    seq[2] = 32'h123451B7; typ[2] = 3'd3;   // lui x3,0x12345
    seq[3] = 32'h020000EF; typ[3] = 3'd4;   // jal x1,32
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1, seq[c], 32'h200 + 32'(c * 4), 0, 1);
      else       drive(0, 32'd0, 32'd0, 0, 1);
      if (c >= 1 && c <= 4) begin
        total++;
        if (imm_type !== typ[c-1]) begin bad++; $display("FAIL b2b_imm_type c=%0d got=%0d exp=%0d", c, imm_type, typ[c-1]); end
      end
      if (c >= 2) begin
        total++;
        if (ex_valid !== 1'b1 || ex_inst !== seq[c-2] || ex_imm !== ref_imm(seq[c-2], typ[c-2])) begin
          bad++; $display("FAIL b2b_ex c=%0d got v=%b inst=%h imm=%h exp inst=%h imm=%h", c, ex_valid, ex_inst,
                          ex_imm, seq[c-2], ref_imm(seq[c-2], typ[c-2]));
        end
      end
      $display("b2b: cycle %0d imm_type=%0d ex_valid=%b ex_inst=%h", c, imm_type, ex_valid, ex_inst);
      tick();
    end
    idle(2);
  endtask

  task automatic test_stall();
    logic [31:0] a, b, cc;
    logic [31:0] got [$];
    a = 32'h00100113; b = 32'h00200193; cc = 32'h00300213;
    drive(1, a, 32'h300, 0, 1); tick();
    drive(1, b, 32'h304, 0, 1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, cc, 32'h308, 0, 0);
      total++;
      if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_inst !== a || ex_pc !== 32'h300) begin
        bad++; $display("FAIL stall_hold k=%0d got rdy=%b v=%b inst=%h pc=%h exp rdy=0 v=1 inst=%h pc=300",
                        k, id_ready, ex_valid, ex_inst, ex_pc, a);
      end
      tick();
    end
    drive(1, cc, 32'h308, 0, 1);
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", id_ready); end
    if (ex_valid) got.push_back(ex_inst);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'd0, 32'd0, 0, 1);
      if (ex_valid) got.push_back(ex_inst);
      tick();
    end
    total++;
    if (got.size() != 3) begin
      bad++; $display("FAIL stall_count got=%0d exp=3", got.size());
    end else if (got[0] !== a || got[1] !== b || got[2] !== cc) begin
      bad++; $display("FAIL stall_order got=%h,%h,%h exp=%h,%h,%h", got[0], got[1], got[2], a, b, cc);
    end
    $display("stall: %0d bundles handed to EX after release", got.size());
  endtask

  task automatic test_flush();
    drive(1, 32'h00100113, 32'h400, 0, 1); tick();
    drive(1, 32'h00200193, 32'h404, 0, 1); tick();
    drive(1, 32'h00300213, 32'h408, 1, 1);
    total++;
    if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_id_ready got=%b exp=0", id_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'd0, 32'd0, 0, 1);
      total++;
      if (ex_valid !== 1'b0 || imm_type !== 3'd7 || id_ready !== 1'b1) begin
        bad++; $display("FAIL flush_after k=%0d got v=%b type=%0d rdy=%b exp v=0 type=7 rdy=1",
                        k, ex_valid, imm_type, id_ready);
      end
      tick();
    end
    $display("flush: pipeline emptied");
  endtask

  task automatic test_hazard();
    logic [31:0] lw, add;
    bit          exp_v [3];
    logic [31:0] exp_i [3];
    lw = 32'h0000A283; add = 32'h00228333;
`ifdef LOAD_USE_HAZARD_EN
    exp_v[0] = 1; exp_i[0] = lw;  exp_v[1] = 0; exp_i[1] = lw; exp_v[2] = 1; exp_i[2] = add;
`else
    exp_v[0] = 1; exp_i[0] = lw;  exp_v[1] = 1; exp_i[1] = add; exp_v[2] = 0; exp_i[2] = add;
`endif
    drive(1, lw, 32'h500, 0, 1); tick();
    drive(1, add, 32'h504, 0, 1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'd0, 32'd0, 0, 1);
      total++;
      if (ex_valid !== exp_v[k] || ex_inst !== exp_i[k]) begin
        bad++; $display("FAIL hazard k=%0d got v=%b inst=%h exp v=%b inst=%h", k, ex_valid, ex_inst, exp_v[k], exp_i[k]);
      end
      $display("hazard: k=%0d ex_valid=%b ex_inst=%h", k, ex_valid, ex_inst);
      tick();
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    drive(1, 32'h0000A283, 32'h600, 0, 1); tick();
    drive(1, 32'h00100113, 32'h604, 0, 1); tick();
    drive(1, 32'h00200193, 32'h608, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1 || imm_type !== 3'd7 ||
        {ex_inst, ex_pc, ex_imm, ex_rd, ex_is_load} !== 102'd0) begin
      bad++; $display("FAIL async_reset got v=%b rdy=%b type=%0d inst=%h pc=%h imm=%h rd=%0d ld=%b exp v=0 rdy=1 type=7 zeros",
                      ex_valid, id_ready, imm_type, ex_inst, ex_pc, ex_imm, ex_rd, ex_is_load);
    end
    tick();
    rst_n = 1'b1;
    drive(0, 32'd0, 32'd0, 0, 1);
    total++;
    if (ex_valid !== 1'b0 || imm_type !== 3'd7) begin
      bad++; $display("FAIL async_reset_release got v=%b type=%0d exp v=0 type=7", ex_valid, imm_type);
    end
    tick();
    $display("async_reset: outputs cleared before clock edge");
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  op;
    case ($urandom_range(0, 9))
      0: op = 7'h13; 1: op = 7'h03; 2: op = 7'h67; 3: op = 7'h23; 4: op = 7'h63;
      5: op = 7'h37; 6: op = 7'h17; 7: op = 7'h6F; 8: op = 7'h33; default: op = 7'h0B;
    endcase
    i = $urandom;
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  task automatic test_random();
    int errs0;
    errs0 = bad;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7);
      total++;
      if (id_ready !== ref_idr()) begin bad++; $display("FAIL rnd_id_ready c=%0d got=%b exp=%b", c, id_ready, ref_idr()); end
      total++;
      if (imm_type !== ref_type(m_id_v, m_id_inst)) begin
        bad++; $display("FAIL rnd_imm_type c=%0d got=%0d exp=%0d", c, imm_type, ref_type(m_id_v, m_id_inst));
      end
      total++;
      if (ex_valid !== m_ex_v) begin bad++; $display("FAIL rnd_ex_valid c=%0d got=%b exp=%b", c, ex_valid, m_ex_v); end
      total++;
      if (ex_inst !== m_ex_inst || ex_pc !== m_ex_pc || ex_imm !== m_ex_imm || ex_rd !== m_ex_rd || ex_is_load !== m_ex_ld) begin
        bad++; $display("FAIL rnd_ex_data c=%0d got inst=%h pc=%h imm=%h rd=%0d ld=%b exp inst=%h pc=%h imm=%h rd=%0d ld=%b",
                        c, ex_inst, ex_pc, ex_imm, ex_rd, ex_is_load, m_ex_inst, m_ex_pc, m_ex_imm, m_ex_rd, m_ex_ld);
      end
      tick();
    end
    $display("random: 400 cycles, %0d new discrepancies", bad - errs0);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_hazard();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
